// File: rtl/int8_dequantizer.sv
// int8_dequantizer: per-block absmax int8 -> fixed-point dequantizer, out = q*max_num/(2^(IN_WIDTH-1)-1), 2-stage pipeline.
// Define DEQUANT_SATURATE_EN to clamp results to the OUT_WIDTH range; otherwise they wrap.
module int8_dequantizer #(
    parameter int IN_WIDTH       = 8,
    parameter int SCALE_WIDTH    = 16,
    parameter int OUT_WIDTH      = 16,
    parameter int OUT_FRAC_WIDTH = 8,
    parameter int PARALLELISM    = 4,
    parameter int IN_SIZE        = 1,
    parameter int BLOCK_DEPTH    = 3,
    parameter int RECIP_SHIFT    = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [PARALLELISM*IN_SIZE*IN_WIDTH-1:0]     data_in_i,
    input  logic                                        data_in_valid_i,
    output logic                                        data_in_ready_o,
    input  logic [SCALE_WIDTH-1:0]                      max_num_i,
    input  logic                                        max_num_valid_i,
    output logic                                        max_num_ready_o,
    output logic [PARALLELISM*IN_SIZE*OUT_WIDTH-1:0]    data_out_o,
    output logic                                        data_out_valid_o,
    input  logic                                        data_out_ready_i
);
    localparam int N    = PARALLELISM * IN_SIZE;
    localparam int CW   = BLOCK_DEPTH > 1 ? $clog2(BLOCK_DEPTH) : 1;
    localparam int PW   = IN_WIDTH + SCALE_WIDTH + 1;
    localparam int QMAX = 2 ** (IN_WIDTH - 1) - 1;
    // Scale and output share OUT_FRAC_WIDTH fractional bits, so no realignment is folded into the shift.
    localparam int SH   = RECIP_SHIFT + 0 * OUT_FRAC_WIDTH;
    localparam int MW   = PW + SH + 1;
    localparam int RECIP = (2 ** SH + QMAX / 2) / QMAX;
    localparam logic signed [MW-1:0] RECIP_M = MW'(RECIP);
    localparam logic signed [MW-1:0] RND_M   = MW'(2 ** (SH - 1));
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic [CW-1:0]              beat_cnt_q, beat_cnt_d;
    logic [SCALE_WIDTH-1:0]     scale_q, scale_d;
    logic                       s1_valid_q, s2_valid_q;
    logic [N-1:0][PW-1:0]       p_q, p_d;
    logic [N-1:0][OUT_WIDTH-1:0] r_q, r_d;
    logic                       adv, in_fire, sc_fire, last;

    always_comb begin
        adv             = !s2_valid_q | data_out_ready_i;
        last            = beat_cnt_q == CW'(BLOCK_DEPTH - 1);
        data_in_ready_o = (state_q == STREAM) & adv;
        in_fire         = data_in_valid_i & data_in_ready_o;
        // A new scale is only taken mid-stream alongside the final beat, so that beat still sees the old scale.
        max_num_ready_o = (state_q == IDLE) | (last & in_fire);
        sc_fire         = max_num_valid_i & max_num_ready_o;
        state_d         = sc_fire ? STREAM : (in_fire & last) ? IDLE : state_q;
        beat_cnt_d      = (sc_fire | (in_fire & last)) ? '0 : in_fire ? beat_cnt_q + 1'b1 : beat_cnt_q;
        scale_d         = sc_fire ? max_num_i : scale_q;
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic signed [MW-1:0] m;
        assign p_d[g] = $signed(PW'($signed(data_in_i[g*IN_WIDTH +: IN_WIDTH]))) * $signed(PW'(scale_q));
        assign m = (MW'($signed(p_q[g])) * RECIP_M + RND_M) >>> SH;
`ifdef DEQUANT_SATURATE_EN
        assign r_d[g] = m > MW'(2 ** (OUT_WIDTH - 1) - 1) ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
                        m < -MW'(2 ** (OUT_WIDTH - 1))    ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : OUT_WIDTH'(m);
`else
        assign r_d[g] = OUT_WIDTH'(m);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            scale_q    <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            p_q        <= '0;
            r_q        <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            scale_q    <= scale_d;
            if (adv) begin
                s1_valid_q <= in_fire;
                p_q        <= p_d;
                s2_valid_q <= s1_valid_q;
                r_q        <= r_d;
            end
        end
    end

    assign data_out_o       = r_q;
    assign data_out_valid_o = s2_valid_q;
endmodule

// File: tb/tb_int8_dequantizer.sv
// tb_int8_dequantizer: directed self-checking bench for int8_dequantizer at default parameters.
module tb_int8_dequantizer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_in_i = '0;
    logic        data_in_valid_i = 1'b0;
    logic        data_in_ready_o;
    logic [15:0] max_num_i = '0;
    logic        max_num_valid_i = 1'b0;
    logic        max_num_ready_o;
    logic [63:0] data_out_o;
    logic        data_out_valid_o;
    logic        data_out_ready_i = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [63:0] got[$];
    int gt[$];
    logic [63:0] held;
    logic [63:0] t2_exp;

    int8_dequantizer dut (
        .clk(clk), .rst(rst),
        .data_in_i(data_in_i), .data_in_valid_i(data_in_valid_i), .data_in_ready_o(data_in_ready_o),
        .max_num_i(max_num_i), .max_num_valid_i(max_num_valid_i), .max_num_ready_o(max_num_ready_o),
        .data_out_o(data_out_o), .data_out_valid_o(data_out_valid_o), .data_out_ready_i(data_out_ready_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (rst && data_out_valid_o && data_out_ready_i) begin
            got.push_back(data_out_o);
            gt.push_back(cyc);
        end

    function automatic logic [31:0] pk8(int a, int b, int c, int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [63:0] pk16(int a, int b, int c, int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef DEQUANT_SATURATE_EN
        t2_exp = 64'h8000_8000_8000_8000;
`else
        t2_exp = 64'h7F01_7F01_7F01_7F01;
`endif
        tick(); tick();
        chk("rst_out_valid", 64'(data_out_valid_o), 64'd0);
        chk("rst_in_ready", 64'(data_in_ready_o), 64'd0);
        chk("rst_max_ready", 64'(max_num_ready_o), 64'd1);
        chk("rst_data_out", data_out_o, 64'd0);
        rst = 1'b1;
        tick();

        // T5: data with no scale is refused
        data_in_i = pk8(5, 5, 5, 5); data_in_valid_i = 1'b1; #1;
        chk("t5_in_ready", 64'(data_in_ready_o), 64'd0);
        tick(); tick(); tick();
        chk("t5_no_out", 64'(got.size()), 64'd0);
        chk("t5_out_valid", 64'(data_out_valid_o), 64'd0);
        data_in_valid_i = 1'b0;

        // T1: 2-cycle latency, mixed signs
        max_num_i = 16'h0200; max_num_valid_i = 1'b1; #1;
        chk("t1_max_ready", 64'(max_num_ready_o), 64'd1);
        tick();
        max_num_valid_i = 1'b0;
        data_in_i = pk8(127, -127, 64, 0); data_in_valid_i = 1'b1; #1;
        chk("t1_in_ready", 64'(data_in_ready_o), 64'd1);
        tick();
        data_in_valid_i = 1'b0;
        chk("t1_lat1_valid", 64'(data_out_valid_o), 64'd0);
        tick();
        chk("t1_lat2_valid", 64'(data_out_valid_o), 64'd1);
        chk("t1_data", data_out_o, pk16('h200, 'hFE00, 'h102, 0));
        data_in_i = '0; data_in_valid_i = 1'b1;
        tick(); tick();
        data_in_valid_i = 1'b0;
        tick(); tick(); tick();
        chk("t1_idle_max_ready", 64'(max_num_ready_o), 64'd1);
        chk("t1_count", 64'(got.size()), 64'd3);
        got.delete(); gt.delete();

        // T2: most negative q against the largest scale
        max_num_i = 16'h7FFF; max_num_valid_i = 1'b1;
        tick();
        max_num_valid_i = 1'b0;
        data_in_i = 32'h8080_8080; data_in_valid_i = 1'b1;
        tick(); tick(); tick();
        data_in_valid_i = 1'b0;
        tick(); tick(); tick();
        chk("t2_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) for (int i = 0; i < 3; i++) chk("t2_data", got[i], t2_exp);
        got.delete(); gt.delete();

        // T3: back-to-back blocks, new scale taken with the last beat
        max_num_i = 16'h0100; max_num_valid_i = 1'b1;
        tick();
        max_num_valid_i = 1'b0;
        data_in_i = 32'h7F7F_7F7F; data_in_valid_i = 1'b1;
        tick(); tick();
        max_num_i = 16'h0200; max_num_valid_i = 1'b1; #1;
        chk("t3_last_max_ready", 64'(max_num_ready_o), 64'd1);
        tick();
        max_num_valid_i = 1'b0;
        chk("t3_in_ready", 64'(data_in_ready_o), 64'd1);
        tick(); tick(); tick();
        data_in_valid_i = 1'b0;
        tick(); tick(); tick();
        chk("t3_count", 64'(got.size()), 64'd6);
        if (got.size() == 6) begin
            for (int i = 0; i < 6; i++)
                chk("t3_data", got[i], i < 3 ? 64'h0100_0100_0100_0100 : 64'h0200_0200_0200_0200);
            chk("t3_no_bubble", 64'(gt[5] - gt[0]), 64'd5);
        end
        got.delete(); gt.delete();

        // T4: 5-cycle output stall mid-block
        max_num_i = 16'h0100; max_num_valid_i = 1'b1;
        tick();
        max_num_valid_i = 1'b0;
        data_in_i = pk8(1, 1, 1, 1); data_in_valid_i = 1'b1;
        tick();
        data_in_i = pk8(2, 2, 2, 2);
        tick();
        data_in_i = pk8(3, 3, 3, 3);
        data_out_ready_i = 1'b0; #1;
        chk("t4_stall_in_ready", 64'(data_in_ready_o), 64'd0);
        held = data_out_o;
        chk("t4_held_first", held, 64'h0002_0002_0002_0002);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_data", data_out_o, held);
            chk("t4_hold_valid", 64'(data_out_valid_o), 64'd1);
            chk("t4_hold_in_ready", 64'(data_in_ready_o), 64'd0);
        end
        data_out_ready_i = 1'b1;
        tick();
        data_in_valid_i = 1'b0;
        tick(); tick(); tick();
        chk("t4_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("t4_b0", got[0], 64'h0002_0002_0002_0002);
            chk("t4_b1", got[1], 64'h0004_0004_0004_0004);
            chk("t4_b2", got[2], 64'h0006_0006_0006_0006);
        end
        got.delete(); gt.delete();

        // T7: zero scale
        max_num_i = 16'h0000; max_num_valid_i = 1'b1;
        tick();
        max_num_valid_i = 1'b0;
        data_in_i = 32'h7F80_7F80; data_in_valid_i = 1'b1;
        tick(); tick(); tick();
        data_in_valid_i = 1'b0;
        tick(); tick(); tick();
        chk("t7_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) chk("t7_zero", got[2], 64'd0);
        got.delete(); gt.delete();

        // T6: reset mid-block
        max_num_i = 16'h0200; max_num_valid_i = 1'b1;
        tick();
        max_num_valid_i = 1'b0;
        data_in_i = 32'h7F7F_7F7F; data_in_valid_i = 1'b1;
        tick(); tick();
        data_in_valid_i = 1'b0;
        rst = 1'b0; #1;
        chk("t6_rst_valid", 64'(data_out_valid_o), 64'd0);
        chk("t6_rst_data", data_out_o, 64'd0);
        chk("t6_rst_in_ready", 64'(data_in_ready_o), 64'd0);
        chk("t6_rst_max_ready", 64'(max_num_ready_o), 64'd1);
        tick();
        rst = 1'b1;
        got.delete(); gt.delete();
        tick(); tick(); tick();
        chk("t6_no_partial", 64'(got.size()), 64'd0);
        chk("t6_idle_in_ready", 64'(data_in_ready_o), 64'd0);
        max_num_i = 16'h0200; max_num_valid_i = 1'b1;
        tick();
        max_num_valid_i = 1'b0;
        data_in_i = pk8(1, 1, 1, 1); data_in_valid_i = 1'b1;
        tick(); tick(); tick();
        data_in_valid_i = 1'b0;
        tick(); tick(); tick();
        chk("t6_count", 64'(got.size()), 64'd3);
        if (got.size() == 3) for (int i = 0; i < 3; i++) chk("t6_data", got[i], 64'h0004_0004_0004_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
